// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle radix-2 restoring divider, {remainder, quotient} result
module iter_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 annul_i,
    input  logic                 stall_i,
    input  logic                 start_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_result;

    logic               w_abort;
    logic               w_last;
    logic               w_div_zero;
    logic               w_start_calc;
    logic               w_start_zero;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;

    assign w_abort      = flush | annul_i;
    assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_div_zero   = (opdata2_i == '0);
    assign w_start_calc = (r_state == S_IDLE) && !w_abort && start_i && !w_div_zero;
    assign w_start_zero = (r_state == S_IDLE) && !w_abort && start_i &&  w_div_zero;

    // Signed operands are reduced to magnitudes; the most negative value maps to itself as unsigned
    assign w_a_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign w_b_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign w_a_mag = w_a_neg ? -opdata1_i : opdata1_i;
    assign w_b_mag = w_b_neg ? -opdata2_i : opdata2_i;

    // One restoring step: shift {rem, quo} left, trial-subtract divisor from the upper half
    always_comb begin
        w_trial   = {r_rem, r_quo[WIDTH-1]};
        w_diff    = w_trial - {1'b0, r_dvsr};
        w_borrow  = w_diff[WIDTH];
        w_rem_nxt = w_borrow ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
        w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};
        w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
        w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an abort overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_state_nxt = w_div_zero ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (!stall_i) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Ready is combinational so a start seen in IDLE stalls EX in the same cycle
    assign ready_o = ((r_state == S_IDLE) && !start_i) || (r_state == S_DONE);

    // Iteration datapath: latch magnitudes and signs on start, then one step per CALC cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvsr  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_start_calc) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvsr  <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end else if ((r_state == S_CALC) && !w_abort) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
        end
    end

    // Result register updates only when DONE is entered; aborts leave the old value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= '0;
        end else if (w_start_zero) begin
            r_result <= {opdata1_i, {WIDTH{1'b1}}};
        end else if ((r_state == S_CALC) && !w_abort && w_last) begin
            r_result <= {w_rem_fix, w_quo_fix};
        end
    end

    assign result_o = r_result;

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - self-checking bench for iter_divider
module tb_iter_divider;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        annul_i;
    logic        stall_i;
    logic        start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        ready_o;
    logic [63:0] result_o;

    int total;
    int bad;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    iter_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .annul_i      (annul_i),
        .stall_i      (stall_i),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .ready_o      (ready_o),
        .result_o     (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Division by arithmetic on 64-bit integers: truncating quotient, remainder takes dividend sign
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one divide and leave the DUT in DONE with start_i still high
    task automatic do_div(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit scramble, input bit drop_start);
        int n;
        int exp_lat;
        exp_lat = (b == 32'd0) ? 1 : 33;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        #1;
        check({name, "_ready_c0"}, 64'(ready_o), 64'd0);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1 && scramble) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~signed_div_i;
                if (drop_start) start_i = 1'b0;
            end
            if (ready_o) break;
        end
        check({name, "_latency"}, 64'(n), 64'(exp_lat));
        check({name, "_result"}, result_o, exp);
    endtask

    task automatic finish_op();
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] prev;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;

        total = 0;
        bad   = 0;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD};
        vecs[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
        vecs[3] = '{1'b0, 32'h12345678,   32'd0,          64'h12345678_FFFFFFFF};
        vecs[4] = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
        vecs[5] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003};
        vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF};
        vecs[7] = '{1'b0, 32'd5,          32'd10,         64'h00000005_00000000};
        vecs[8] = '{1'b1, 32'hFFFFFFF9,   32'd0,          64'hFFFFFFF9_FFFFFFFF};
        vecs[9] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000};

        rst          = 1'b0;
        flush        = 1'b0;
        annul_i      = 1'b0;
        stall_i      = 1'b0;
        start_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        #1;
        check("reset_ready", 64'(ready_o), 64'd1);
        check("reset_result", result_o, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 1'b0);
            finish_op();
            check($sformatf("vec%0d_idle_ready", i), 64'(ready_o), 64'd1);
        end

        // Flush in cycle 10: back to IDLE next cycle, result untouched, then a fresh divide
        prev = result_o;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush   = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_ready", 64'(ready_o), 64'd1);
        check("flush_result_held", result_o, prev);
        do_div("after_flush", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0, 1'b0);
        finish_op();

        // Annul behaves like flush
        prev = result_o;
        @(negedge clk);
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFFFF00;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        check("annul_ready", 64'(ready_o), 64'd1);
        check("annul_result_held", result_o, prev);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd9;
        start_i      = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("async_rst_ready", 64'(ready_o), 64'd1);
        check("async_rst_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Stall held in DONE with start still high: result held, no restart
        stall_i = 1'b1;
        do_div("stall", 1'b0, 32'd1000, 32'd9, 64'h00000001_0000006F, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall_ready%0d", i), 64'(ready_o), 64'd1);
            check($sformatf("stall_result%0d", i), result_o, 64'h00000001_0000006F);
        end
        @(negedge clk);
        stall_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("stall_release_ready", 64'(ready_o), 64'd1);

        // Randomized operands against the arithmetic model; operands scrambled after acceptance
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(1, 15));
                1:       b = -32'($urandom_range(1, 15));
                2:       b = (i % 7 == 0) ? 32'd0 : $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_div($sformatf("rand%0d", i), s, a, b, ref_div(s, a, b), 1'b1, (i % 3 == 0));
            finish_op();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
